// File: rtl/ctrl_sequencer.sv
// CPU control state register: holds the state code, stalls on memory handshake with timeout
// recovery, and decodes the state into datapath strobes. Optional retire counter: CTRL_RETIRE_CNT_EN.
module ctrl_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       next_state,
  input  logic [15:0]      instr,
  input  logic             mem_ready,
  output logic [7:0]       state,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic             a_load,
  output logic             g_load,
  output logic [1:0]       alu_op,
  output logic             flags_we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             mem_asel,
  output logic             sp_inc,
  output logic             sp_dec,
  output logic             bus_err
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  typedef enum logic [7:0] {
    S_FETCH0 = 8'h00, S_FETCH1 = 8'h0F, S_DECODE = 8'h01,
    S_MOVI   = 8'h02, S_MOVR   = 8'h03, S_MOVPC  = 8'h04, S_JMP    = 8'h05,
    S_SUB_A  = 8'h06, S_SUB_G  = 8'h07, S_SUB_W  = 8'h08,
    S_ADD_A  = 8'h09, S_ADD_G  = 8'h0A, S_ADD_W  = 8'h0B,
    S_XOR_A  = 8'h0C, S_XOR_G  = 8'h0D, S_XOR_W  = 8'h0E,
    S_PUSH0  = 8'h13, S_PUSH1  = 8'h14,
    S_POP0   = 8'h17, S_POP1   = 8'h18, S_POP2   = 8'h19,
    S_CALL0  = 8'h1B, S_CALL1  = 8'h1C, S_CALL2  = 8'h1D,
    S_RET0   = 8'h21, S_RET1   = 8'h22, S_RET2   = 8'h23,
    S_CPU_A  = 8'h26, S_CPU_G  = 8'h27, S_BREQ   = 8'h2A
  } state_e;

  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_bus_err;
  logic       w_timeout;
  logic       w_unused_instr;

  // The instruction fields are consumed by the datapath; the sequencer only passes strobes.
  assign w_unused_instr = ^instr;

  assign state   = r_state;
  assign bus_err = r_bus_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH0;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_bus_err  <= w_timeout;
    end
  end

  always_comb begin
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    rf_we       = 1'b0;
    rf_wsel     = 2'b00;
    a_load      = 1'b0;
    g_load      = 1'b0;
    alu_op      = 2'b00;
    flags_we    = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_asel    = 1'b0;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_timeout   = 1'b0;

    case (r_state)
      S_FETCH0: mem_rd = 1'b1;
      S_FETCH1: begin
        mem_rd  = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
      end
      S_MOVI:   begin rf_we = 1'b1; rf_wsel = 2'b01; end
      S_MOVR:   begin rf_we = 1'b1; rf_wsel = 2'b10; end
      S_MOVPC:  begin rf_we = 1'b1; rf_wsel = 2'b11; end
      S_JMP, S_CALL2, S_RET1, S_BREQ: pc_load = 1'b1;
      S_ADD_A, S_SUB_A, S_XOR_A, S_CPU_A: a_load = 1'b1;
      S_ADD_G:  g_load = 1'b1;
      S_SUB_G:  begin g_load = 1'b1; alu_op = 2'b01; end
      S_XOR_G:  begin g_load = 1'b1; alu_op = 2'b10; end
      S_CPU_G:  begin g_load = 1'b1; alu_op = 2'b01; flags_we = 1'b1; end
      S_ADD_W, S_SUB_W, S_XOR_W: begin rf_we = 1'b1; flags_we = 1'b1; end
      S_POP1:   rf_we = 1'b1;
      S_PUSH0, S_CALL0: sp_dec = 1'b1;
      S_POP2, S_RET2:   sp_inc = 1'b1;
      S_PUSH1, S_CALL1: begin mem_wr = 1'b1; mem_asel = 1'b1; end
      S_POP0, S_RET0:   begin mem_rd = 1'b1; mem_asel = 1'b1; end
      default: ;
    endcase

    // Memory states wait for mem_ready; completion on the last allowed cycle beats the timeout.
    if (mem_rd || mem_wr) begin
      if (mem_ready) begin
        w_state_nxt = state_e'(next_state);
      end else if (r_wait_cnt == 8'(TIMEOUT - 1)) begin
        w_state_nxt = S_FETCH0;
        w_timeout   = 1'b1;
      end else begin
        w_cnt_nxt = r_wait_cnt + 8'd1;
      end
    end else begin
      w_state_nxt = state_e'(next_state);
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retired;

  assign retired = r_retired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
    end else if ((r_state != S_FETCH0) && (w_state_nxt == S_FETCH0) && !w_timeout) begin
      r_retired <= r_retired + 1'b1;
    end
  end
`endif

endmodule
